// File: rtl/banked_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : banked_dot_sequencer
// Brief   : Ping-pong banked per-channel dot pattern player with step timer and
//           loop control. Define SEQ_INVERT_EN to add the inv_mask port.
// Rev     : 1.0  initial release
// ============================================================================
module banked_dot_sequencer #(
    parameter int NUM_CHANNELS = 16,
    parameter int CH_SEL_W     = 4,
    parameter int MEM_DEPTH    = 48,
    parameter int ADDR_W       = 6,
    parameter int PRESCALE_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [CH_SEL_W-1:0]     wr_channel,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [1:0]              wr_data,
    input  logic                    cfg_wr,
    input  logic [PRESCALE_W-1:0]   cfg_period,
    input  logic [ADDR_W-1:0]       cfg_length,
    input  logic [7:0]              cfg_loops,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    swap_req,
`ifdef SEQ_INVERT_EN
    input  logic [NUM_CHANNELS-1:0] inv_mask,
`endif
    output logic [NUM_CHANNELS-1:0] dot_enable,
    output logic [NUM_CHANNELS-1:0] dot_state,
    output logic                    busy,
    output logic [ADDR_W-1:0]       step_index,
    output logic                    active_bank,
    output logic                    swap_pending,
    output logic                    cycle_done
);

    localparam logic [0:0]          c_ST_IDLE = 1'b0;
    localparam logic [0:0]          c_ST_RUN  = 1'b1;
    localparam logic [ADDR_W:0]     c_DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [CH_SEL_W:0]   c_NCH_X   = (CH_SEL_W+1)'(NUM_CHANNELS);

    logic [0:0]              r_state;
    logic [0:0]              w_next_state;
    logic [PRESCALE_W-1:0]   r_period;
    logic [ADDR_W-1:0]       r_length;
    logic [7:0]              r_loops;
    logic [7:0]              r_loop_cnt;
    logic [PRESCALE_W-1:0]   r_presc;
    logic [ADDR_W-1:0]       r_step;
    logic                    r_active_bank;
    logic                    r_swap_pending;
    logic                    r_cycle_done;
    logic [NUM_CHANNELS-1:0] r_dot_enable;
    logic [NUM_CHANNELS-1:0] r_dot_state;
    logic [NUM_CHANNELS-1:0] w_rd_en;
    logic [NUM_CHANNELS-1:0] w_rd_st;
    logic [NUM_CHANNELS-1:0] w_st_out;
    logic [ADDR_W-1:0]       w_cfg_length;
    logic                    w_wr_ok;
    logic                    w_tick;
    logic                    w_last;
    logic                    w_cycle_end;
    logic                    w_start_ok;
    logic                    w_final;
`ifdef SEQ_INVERT_EN
    logic [NUM_CHANNELS-1:0] r_inv_mask;
`endif

    assign w_wr_ok      = ({1'b0, wr_addr} < c_DEPTH_X) && ({1'b0, wr_channel} < c_NCH_X);
    assign w_cfg_length = ({1'b0, cfg_length} > c_DEPTH_X) ? ADDR_W'(MEM_DEPTH) : cfg_length;

    // Per-channel storage; host writes always go to the bank not being played.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [1:0] r_mem [2][MEM_DEPTH];
        logic       w_we;
        assign w_we = wr_en && w_wr_ok && (wr_channel == CH_SEL_W'(g));
        always_ff @(posedge clock) begin
            if (w_we) begin
                r_mem[~r_active_bank][wr_addr] <= wr_data;
            end
        end
        assign w_rd_en[g] = r_mem[r_active_bank][r_step][1];
        assign w_rd_st[g] = r_mem[r_active_bank][r_step][0];
    end

`ifdef SEQ_INVERT_EN
    assign w_st_out = w_rd_en & (w_rd_st ^ r_inv_mask);
`else
    assign w_st_out = w_rd_st;
`endif

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic (stop dominates start and the step tick)
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_ok)      w_next_state = c_ST_RUN;
            c_ST_RUN:  if (stop || w_final) w_next_state = c_ST_IDLE;
            default:                        w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM: output / event decode
    always_comb begin
        w_tick      = (r_presc == r_period);
        w_last      = (r_step == (r_length - ADDR_W'(1)));
        w_cycle_end = (r_state == c_ST_RUN) && !stop && w_tick && w_last;
        w_start_ok  = (r_state == c_ST_IDLE) && start && !stop && (r_length != '0);
        w_final     = w_cycle_end && (r_loops != 8'd0) && (r_loop_cnt == 8'd1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_period       <= '0;
            r_length       <= '0;
            r_loops        <= '0;
            r_loop_cnt     <= '0;
            r_presc        <= '0;
            r_step         <= '0;
            r_active_bank  <= 1'b0;
            r_swap_pending <= 1'b0;
            r_cycle_done   <= 1'b0;
`ifdef SEQ_INVERT_EN
            r_inv_mask     <= '0;
`endif
        end else begin
            r_cycle_done <= w_cycle_end;
            if (cfg_wr && (r_state == c_ST_IDLE)) begin
                r_period <= cfg_period;
                r_length <= w_cfg_length;
                r_loops  <= cfg_loops;
`ifdef SEQ_INVERT_EN
                r_inv_mask <= inv_mask;
`endif
            end
            if (w_start_ok) begin
                r_step     <= '0;
                r_presc    <= '0;
                r_loop_cnt <= r_loops;
            end else if ((r_state == c_ST_RUN) && !stop) begin
                if (!w_tick) begin
                    r_presc <= r_presc + PRESCALE_W'(1);
                end else begin
                    r_presc <= '0;
                    if (w_last) begin
                        r_step <= '0;
                        if (r_loops != 8'd0) r_loop_cnt <= r_loop_cnt - 8'd1;
                    end else begin
                        r_step <= r_step + ADDR_W'(1);
                    end
                end
            end
            // A request landing on the boundary itself swaps immediately.
            if (r_state == c_ST_IDLE) begin
                if (swap_req) r_active_bank <= ~r_active_bank;
            end else if (w_cycle_end && (r_swap_pending || swap_req)) begin
                r_active_bank  <= ~r_active_bank;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    // Registered read of the playing bank, one clock behind step/bank changes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_dot_enable <= '0;
            r_dot_state  <= '0;
        end else if ((r_state == c_ST_RUN) && !stop) begin
            r_dot_enable <= w_rd_en;
            r_dot_state  <= w_st_out;
        end else begin
            r_dot_enable <= '0;
            r_dot_state  <= '0;
        end
    end

    assign dot_enable   = r_dot_enable;
    assign dot_state    = r_dot_state;
    assign busy         = (r_state == c_ST_RUN);
    assign step_index   = r_step;
    assign active_bank  = r_active_bank;
    assign swap_pending = r_swap_pending;
    assign cycle_done   = r_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_banked_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_banked_dot_sequencer
// Brief   : Directed, table-driven bench for banked_dot_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_banked_dot_sequencer;

    localparam int NCH = 16;
    localparam int CHW = 5;
    localparam int DEP = 48;
    localparam int AW  = 6;
    localparam int PW  = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            wr_en;
    logic [CHW-1:0]  wr_channel;
    logic [AW-1:0]   wr_addr;
    logic [1:0]      wr_data;
    logic            cfg_wr;
    logic [PW-1:0]   cfg_period;
    logic [AW-1:0]   cfg_length;
    logic [7:0]      cfg_loops;
    logic            start;
    logic            stop;
    logic            swap_req;
    logic [NCH-1:0]  dot_enable;
    logic [NCH-1:0]  dot_state;
    logic            busy;
    logic [AW-1:0]   step_index;
    logic            active_bank;
    logic            swap_pending;
    logic            cycle_done;
`ifdef SEQ_INVERT_EN
    logic [NCH-1:0]  inv_mask;
    logic            inv3 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    banked_dot_sequencer #(
        .NUM_CHANNELS(NCH), .CH_SEL_W(CHW), .MEM_DEPTH(DEP), .ADDR_W(AW), .PRESCALE_W(PW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_channel(wr_channel), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_wr(cfg_wr), .cfg_period(cfg_period), .cfg_length(cfg_length), .cfg_loops(cfg_loops),
        .start(start), .stop(stop), .swap_req(swap_req),
`ifdef SEQ_INVERT_EN
        .inv_mask(inv_mask),
`endif
        .dot_enable(dot_enable), .dot_state(dot_state), .busy(busy), .step_index(step_index),
        .active_bank(active_bank), .swap_pending(swap_pending), .cycle_done(cycle_done)
    );

    always #5 clock = ~clock;

    // Expected dot_state for channel 3 given its stored {enable,state} word.
`ifdef SEQ_INVERT_EN
    function automatic logic exp_st(input logic [1:0] w);
        return w[1] & (w[0] ^ inv3);
    endfunction
`else
    function automatic logic exp_st(input logic [1:0] w);
        return w[0];
    endfunction
`endif

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       swap;
        logic       busy;
        logic [5:0] step;
        logic       bank;
        logic       pend;
        logic       cd;
        logic [1:0] word;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input int ch, input int addr, input logic [1:0] d);
        wr_en = 1'b1; wr_channel = CHW'(ch); wr_addr = AW'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic configure(input int period, input int length, input int loops);
        cfg_wr = 1'b1; cfg_period = PW'(period); cfg_length = AW'(length); cfg_loops = 8'(loops);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   times [8];
        int   n;
        int   end_t;
        int   e;
        int   maxstep;
        logic got;

        reset_n = 1'b0; wr_en = 1'b0; wr_channel = '0; wr_addr = '0; wr_data = '0;
        cfg_wr = 1'b0; cfg_period = '0; cfg_length = '0; cfg_loops = '0;
        start = 1'b0; stop = 1'b0; swap_req = 1'b0;
`ifdef SEQ_INVERT_EN
        inv_mask = '0;
`endif
        // {start,stop,swap, busy,step,bank,pend,cd, ch3 word}
        tbl[0] = {1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[1] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[2] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[3] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[4] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[5] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 2'd2};
        tbl[6] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 2'd2};
        tbl[7] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 2'd3};
        tbl[8] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 2'd3};
        tbl[9] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0};

        repeat (2) tick();
        check("reset_outputs",
              {dot_enable, dot_state, busy, step_index, active_bank, swap_pending, cycle_done}, '0);
        reset_n = 1'b1;
        tick();

        // Basic play of the shadow bank after an idle swap
        write_word(3, 0, 2'd3); write_word(3, 1, 2'd1);
        write_word(3, 2, 2'd2); write_word(3, 3, 2'd3);
        configure(1, 4, 1);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check("idle_swap_bank", active_bank, 1);
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; swap_req = tbl[i].swap;
            tick();
            start = 1'b0; stop = 1'b0; swap_req = 1'b0;
            check($sformatf("vec[%0d]", i),
                  {busy, step_index, active_bank, swap_pending, cycle_done, dot_enable[3], dot_state[3]},
                  {tbl[i].busy, tbl[i].step, tbl[i].bank, tbl[i].pend, tbl[i].cd,
                   tbl[i].word[1], exp_st(tbl[i].word)});
        end
        check("idle_buses_zero", {dot_enable, dot_state}, '0);

        // Loop count: 3 cycles of 2 steps at one step per clock
        configure(0, 2, 3);
        pulse_start();
        n = 0; end_t = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cycle_done && n < 8) begin times[n] = k; n++; end
            if (!busy && end_t < 0) end_t = k;
        end
        check("loop_pulse_count", n, 3);
        if (n == 3) begin
            check("loop_first_pulse", times[0], 2);
            check("loop_gap_1", times[1] - times[0], 2);
            check("loop_gap_2", times[2] - times[1], 2);
        end
        check("loop_busy_fall", end_t, 6);

        // Swap requested mid-cycle while running forever
        write_word(3, 0, 2'd2); write_word(3, 1, 2'd2);
        write_word(3, 2, 2'd2); write_word(3, 3, 2'd2);
        configure(1, 4, 0);
        pulse_start();
        repeat (3) tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check("swap_pending_set", {swap_pending, active_bank}, {1'b1, 1'b1});
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cycle_done) begin got = 1'b1; break; end
            check("swap_pending_hold", swap_pending, 1);
        end
        check("swap_boundary_seen", got, 1);
        check("swap_boundary", {active_bank, swap_pending, step_index}, {1'b0, 1'b0, 6'd0});
        tick();
        check("new_bank_data", {dot_enable[3], dot_state[3]}, {1'b1, exp_st(2'd2)});

        // swap_req on the boundary clock itself swaps at once
        repeat (6) tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check("coincident_swap", {cycle_done, active_bank, swap_pending}, {1'b1, 1'b1, 1'b0});

        // Stop at step 2 with a swap armed
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (step_index == 6'd2) begin got = 1'b1; break; end
        end
        check("reach_step2", got, 1);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_outputs", {busy, cycle_done, dot_enable, dot_state}, '0);
        check("stop_keeps_pending", swap_pending, 1);
        tick();
        check("stop_no_cycle_done", {busy, cycle_done}, 2'b00);
        pulse_start();
        check("restart_step0", {busy, step_index}, {1'b1, 6'd0});
        stop = 1'b1; tick(); stop = 1'b0;
        check("restart_stop", {busy, swap_pending}, {1'b0, 1'b1});

        // Zero length start is ignored
        configure(0, 0, 0);
        pulse_start();
        check("len0_idle", busy, 0);
        tick();
        check("len0_still_idle", busy, 0);

        // Length 60 clamps to 48; config while busy is ignored
        configure(0, 60, 1);
        pulse_start();
        cfg_wr = 1'b1; cfg_period = PW'(5); cfg_length = AW'(2); cfg_loops = 8'd0;
        tick();
        cfg_wr = 1'b0;
        e = 1; maxstep = 0; got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            e++;
            if (cycle_done) begin got = 1'b1; break; end
            if (int'(step_index) > maxstep) maxstep = int'(step_index);
        end
        check("len60_done_seen", got, 1);
        check("len60_cycle_clocks", e, 48);
        check("len60_max_step", maxstep, 47);
        check("len60_end_state", {busy, active_bank, swap_pending}, 3'b000);

        // Out-of-range writes are dropped; write with swap lands in old shadow
        write_word(1, 0, 2'd3); write_word(1, 1, 2'd3);
        write_word(17, 0, 2'd0); write_word(17, 1, 2'd0);
        write_word(3, 50, 2'd0);
        wr_en = 1'b1; wr_channel = CHW'(3); wr_addr = AW'(1); wr_data = 2'd2; swap_req = 1'b1;
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        check("write_swap_bank", active_bank, 1);
        configure(0, 2, 1);
        pulse_start();
        tick();
        check("bad_write_step0", {dot_enable[1], dot_state[1], dot_enable[3], dot_state[3]},
              {1'b1, exp_st(2'd3), 1'b1, exp_st(2'd3)});
        tick();
        check("swap_write_step1", {dot_enable[1], dot_state[1], dot_enable[3], dot_state[3], cycle_done, busy},
              {1'b1, exp_st(2'd3), 1'b1, exp_st(2'd2), 1'b1, 1'b0});

`ifdef SEQ_INVERT_EN
        inv_mask = '0; inv_mask[3] = 1'b1; inv3 = 1'b1;
        configure(0, 2, 1);
        pulse_start();
        tick();
        check("invert_step0", {dot_enable[3], dot_state[3]}, {1'b1, exp_st(2'd3)});
        tick();
        check("invert_step1", {dot_enable[3], dot_state[3]}, {1'b1, exp_st(2'd2)});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
